kernel_pr_start_fork_fifo: RTL and testbench
============================================

KERNEL_PR_START_FORK_FIFO -- requirements
Module: kernel_pr_start_fork_fifo

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 1, the token width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 2, the storage index width, with DEPTH <= 2**ADDR_WIDTH.
REQ-003 The block SHALL have parameter DEPTH, default 4, the entries per fork, legal range 2..2**ADDR_WIDTH and not required to be a power of two.
REQ-004 The block SHALL have parameter NUM_RD, default 2, the number of independent consumers, legal range 1..8.
REQ-005 The block SHALL have parameter AFULL_THRESH, default DEPTH-1, the occupancy at which almost-full asserts, legal range 1..DEPTH.
REQ-006 The block SHALL have one clock and one reset: reset is synchronous and active-high.
REQ-007 Port clk, input, 1 bit: the sole clock, rising edge.
REQ-008 Port reset, input, 1 bit: synchronous, active-high.
REQ-009 Port if_write, input, 1 bit: the producer write request.
REQ-010 Port if_write_ce, input, 1 bit: the write clock-enable; the write is effective only when if_write, if_write_ce and if_full_n are all 1.
REQ-011 Port if_din, input, DATA_WIDTH bits: the write data.
REQ-012 Port if_full_n, output, 1 bit: 1 when the block can accept a write.
REQ-013 Port if_almost_full_n, output, 1 bit: 0 when occupancy >= AFULL_THRESH.
REQ-014 Port if_count, output, ADDR_WIDTH+1 bits: the global occupancy.
REQ-015 Port if_read, input, NUM_RD bits: per-consumer read request.
REQ-016 Port if_read_ce, input, NUM_RD bits: per-consumer read clock-enable.
REQ-017 Port if_empty_n, output, NUM_RD bits: per-consumer data-valid.
REQ-018 Port if_dout, output, NUM_RD*DATA_WIDTH bits: per-consumer head data, with consumer i in bits [i*DATA_WIDTH +: DATA_WIDTH].

Function
REQ-019 Each written token SHALL be delivered once to every consumer, in write order; storage is freed only after all NUM_RD consumers have read the token.
REQ-020 A per-consumer counter cnt[i] (ADDR_WIDTH+1 bits) SHALL track the tokens not yet read by consumer i; the global occupancy SHALL be max(cnt[i]).
REQ-021 An effective write SHALL shift storage (newest at index 0) and increment every cnt[i], except for a consumer performing an effective read in the same cycle.
REQ-022 An effective read for consumer i is if_read[i] & if_read_ce[i] & if_empty_n[i]; it SHALL decrement cnt[i] unless a write occurs in the same cycle, in which case cnt[i] is held.
REQ-023 if_dout[i] SHALL be show-ahead: combinationally the entry at index cnt[i]-1, or index 0 when cnt[i]=0, with contents undefined when empty.
REQ-024 if_empty_n[i] SHALL be registered and equal (cnt[i] != 0) from the cycle after the update, giving a write-to-valid latency of 1 cycle.
REQ-025 if_full_n SHALL be registered and equal (occupancy != DEPTH); a write while if_full_n=0 SHALL be ignored, leaving no state change.
REQ-026 A read on an empty consumer SHALL be ignored.
REQ-027 if_almost_full_n and if_count SHALL be registered, consistent with if_full_n in the same cycle.
REQ-028 A simultaneous write and all-consumer read at full SHALL be impossible; the write is blocked by if_full_n=0, and the reads proceed.
REQ-029 A slow consumer SHALL back-pressure the producer; fast consumers are never stalled by other consumers.
REQ-030 The counters SHALL never wrap; cnt[i] is bounded to 0..DEPTH by REQ-025 and REQ-026.

Reset
REQ-031 On reset=1 at a clock edge, all cnt[i] SHALL become 0, if_empty_n all 0, if_full_n 1, if_almost_full_n 1, and if_count 0.
REQ-032 Reset SHALL override any concurrent read or write, and storage contents need not be cleared.
REQ-033 Power-up register values SHALL equal the reset values.

Structure
REQ-034 A shared package kernel_pr_fifo_pkg SHALL hold the clog2 helper and the effective-read/write predicate definitions, reused by all start/stream FIFOs.
REQ-035 Storage SHALL be one sub-module, kernel_pr_start_fork_fifo_shiftReg: a DEPTH x DATA_WIDTH shift register with a ce input and NUM_RD independent read addresses.

Verification
REQ-036 Reset, then write 0xA,0xB (DATA_WIDTH=4, NUM_RD=2) with no reads -> if_empty_n=2'b11 one cycle after the first write, both douts=0xA, if_count=2.
REQ-037 From REQ-036: consumer 0 reads twice, consumer 1 idle -> consumer 0 empty, consumer 1 dout=0xA, if_count stays 2, if_full_n=1.
REQ-038 DEPTH=4: write 4 tokens, no reads -> if_full_n=0 and if_almost_full_n=0; a 5th write is ignored and if_count=4.
REQ-039 Full, consumer 0 reads all 4, consumer 1 reads 1 -> if_count=3, if_full_n=1 the next cycle; the next write is accepted.
REQ-040 Every cycle, write together with reads on both consumers at count=2 -> count stays 2, with data order preserved across 20 tokens.
REQ-041 Assert reset mid-stream at count=3 together with a write -> the next cycle gives if_count=0, if_empty_n=0, if_full_n=1.

Source files
------------

// File: rtl/kernel_pr_fifo_pkg.sv
// Shared helpers for the start/stream FIFO family: clog2 and the
// effective-handshake predicates used by every FIFO flavour.
package kernel_pr_fifo_pkg;

    // Ceiling log2, minimum 1, for sizing index fields from a depth.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // A write lands only when requested, enabled and there is room.
    function automatic logic eff_wr(input logic write, input logic ce, input logic full_n);
        return write & ce & full_n;
    endfunction

    // A read lands only when requested, enabled and data is present.
    function automatic logic eff_rd(input logic read, input logic ce, input logic empty_n);
        return read & ce & empty_n;
    endfunction

endpackage

// File: rtl/kernel_pr_start_fork_fifo_shiftReg.sv
// DEPTH x DATA_WIDTH shift register, newest entry at index 0, with
// NUM_RD independent combinational read ports.
module kernel_pr_start_fork_fifo_shiftReg #(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 2,
    parameter int DEPTH      = 4,
    parameter int NUM_RD     = 2
) (
    input  logic                                 clk,
    input  logic                                 ce,
    input  logic [DATA_WIDTH-1:0]                d,
    input  logic [NUM_RD-1:0][ADDR_WIDTH-1:0]    a,
    output logic [NUM_RD-1:0][DATA_WIDTH-1:0]    q
);

    logic [DEPTH-1:0][DATA_WIDTH-1:0] sr;

    // Shift in a new token on every effective write; contents are never reset.
    always_ff @(posedge clk) begin
        if (ce) sr <= {sr[DEPTH-2:0], d};
    end

    // Per-consumer read mux; addresses beyond DEPTH-1 cannot occur since cnt <= DEPTH.
    always_comb begin
        for (int i = 0; i < NUM_RD; i++) begin
            q[i] = sr[0];
            for (int j = 0; j < DEPTH; j++) begin
                if (a[i] == ADDR_WIDTH'(j)) q[i] = sr[j];
            end
        end
    end

endmodule

// File: rtl/kernel_pr_start_fork_fifo.sv
// Fork FIFO: one producer, NUM_RD consumers. Every token is delivered once
// to every consumer in order; a slot is freed only after the slowest
// consumer has read it, so the global occupancy is the largest per-consumer
// backlog.
module kernel_pr_start_fork_fifo
    import kernel_pr_fifo_pkg::*;
#(
    parameter int DATA_WIDTH   = 1,
    parameter int ADDR_WIDTH   = 2,
    parameter int DEPTH        = 4,
    parameter int NUM_RD       = 2,
    parameter int AFULL_THRESH = DEPTH - 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         if_write,
    input  logic                         if_write_ce,
    input  logic [DATA_WIDTH-1:0]        if_din,
    output logic                         if_full_n,
    output logic                         if_almost_full_n,
    output logic [ADDR_WIDTH:0]          if_count,
    input  logic [NUM_RD-1:0]            if_read,
    input  logic [NUM_RD-1:0]            if_read_ce,
    output logic [NUM_RD-1:0]            if_empty_n,
    output logic [NUM_RD*DATA_WIDTH-1:0] if_dout
);

    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AFULL_C = (ADDR_WIDTH+1)'(AFULL_THRESH);

    // Registered state; declaration values make power-up match reset.
    logic [NUM_RD-1:0][ADDR_WIDTH:0] cnt       = '0;
    logic [NUM_RD-1:0]               empty_n_r = '0;
    logic                            full_n_r  = 1'b1;
    logic                            afull_n_r = 1'b1;
    logic [ADDR_WIDTH:0]             count_r   = '0;

    logic                              wr_eff;
    logic [NUM_RD-1:0]                 rd_eff;
    logic [NUM_RD-1:0][ADDR_WIDTH:0]   cnt_nxt;
    logic [ADDR_WIDTH:0]               occ_nxt;
    logic [ADDR_WIDTH:0]               head;
    logic [NUM_RD-1:0][ADDR_WIDTH-1:0] rd_addr;
    logic [NUM_RD-1:0][DATA_WIDTH-1:0] rd_data;

    assign wr_eff = eff_wr(if_write, if_write_ce, full_n_r);

    // Per-consumer counter update, head address and global occupancy (max backlog).
    always_comb begin
        occ_nxt = '0;
        head    = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            rd_eff[i] = eff_rd(if_read[i], if_read_ce[i], empty_n_r[i]);
            case ({wr_eff, rd_eff[i]})
                2'b10:   cnt_nxt[i] = cnt[i] + 1'b1;
                2'b01:   cnt_nxt[i] = cnt[i] - 1'b1;
                default: cnt_nxt[i] = cnt[i];
            endcase
            if (cnt_nxt[i] > occ_nxt) occ_nxt = cnt_nxt[i];
            // Oldest unread token sits at cnt-1 because newer ones pushed it up.
            head       = (cnt[i] == '0) ? '0 : cnt[i] - 1'b1;
            rd_addr[i] = head[ADDR_WIDTH-1:0];
        end
    end

    // Counters and status flags; reset wins over any concurrent read or write.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            empty_n_r <= '0;
            full_n_r  <= 1'b1;
            afull_n_r <= 1'b1;
            count_r   <= '0;
        end else begin
            cnt <= cnt_nxt;
            for (int i = 0; i < NUM_RD; i++) empty_n_r[i] <= (cnt_nxt[i] != '0);
            full_n_r  <= (occ_nxt != DEPTH_C);
            afull_n_r <= (occ_nxt < AFULL_C);
            count_r   <= occ_nxt;
        end
    end

    kernel_pr_start_fork_fifo_shiftReg #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH),
        .NUM_RD     (NUM_RD)
    ) u_sr (
        .clk (clk),
        .ce  (wr_eff),
        .d   (if_din),
        .a   (rd_addr),
        .q   (rd_data)
    );

    assign if_full_n        = full_n_r;
    assign if_almost_full_n = afull_n_r;
    assign if_count         = count_r;
    assign if_empty_n       = empty_n_r;
    assign if_dout          = rd_data;

endmodule

// File: tb/tb_kernel_pr_start_fork_fifo.sv
// Bench for the fork FIFO: a per-consumer token queue model with a
// scoreboard monitor on the falling edge, plus directed scenarios and
// a randomized phase.
module tb_kernel_pr_start_fork_fifo;

    localparam int DW = 4, AW = 2, D = 4, NR = 2, AF = D - 1;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              if_write = 1'b0, if_write_ce = 1'b0;
    logic [DW-1:0]     if_din = '0;
    logic              if_full_n, if_almost_full_n;
    logic [AW:0]       if_count;
    logic [NR-1:0]     if_read = '0, if_read_ce = '0;
    logic [NR-1:0]     if_empty_n;
    logic [NR*DW-1:0]  if_dout;

    int errors = 0;
    int checks = 0;

    // Model: the tokens each consumer still has to read, oldest first.
    logic [DW-1:0] sb [NR][$];

    always #5 clk = ~clk;

    kernel_pr_start_fork_fifo #(
        .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .DEPTH (D), .NUM_RD (NR), .AFULL_THRESH (AF)
    ) dut (
        .clk (clk), .reset (reset),
        .if_write (if_write), .if_write_ce (if_write_ce), .if_din (if_din),
        .if_full_n (if_full_n), .if_almost_full_n (if_almost_full_n), .if_count (if_count),
        .if_read (if_read), .if_read_ce (if_read_ce),
        .if_empty_n (if_empty_n), .if_dout (if_dout)
    );

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endfunction

    function automatic int model_occ();
        int m = 0;
        for (int i = 0; i < NR; i++) if (sb[i].size() > m) m = sb[i].size();
        return m;
    endfunction

    // Monitor: compare flags against the model, then apply the coming edge's
    // handshakes to the model, popping/comparing data on each effective read.
    always @(negedge clk) begin
        int  occ;
        logic wr;
        occ = model_occ();
        chk("count", int'(if_count), occ);
        chk("full_n", int'(if_full_n), int'(occ != D));
        chk("almost_full_n", int'(if_almost_full_n), int'(occ < AF));
        for (int i = 0; i < NR; i++)
            chk($sformatf("empty_n[%0d]", i), int'(if_empty_n[i]), int'(sb[i].size() != 0));
        if (reset) begin
            for (int i = 0; i < NR; i++) sb[i].delete();
        end else begin
            wr = if_write && if_write_ce && (occ != D);
            for (int i = 0; i < NR; i++) begin
                if (if_read[i] && if_read_ce[i] && sb[i].size() != 0)
                    chk($sformatf("dout[%0d]", i), int'(if_dout[i*DW +: DW]), int'(sb[i].pop_front()));
            end
            if (wr) for (int i = 0; i < NR; i++) sb[i].push_back(if_din);
        end
    end

    // One clock of stimulus; inputs change just after the rising edge.
    task automatic cyc(input logic w, input logic [DW-1:0] din, input logic [NR-1:0] rd);
        if_write    = w;
        if_write_ce = w;
        if_din      = din;
        if_read     = rd;
        if_read_ce  = rd;
        @(posedge clk);
        #1;
        if_write = 1'b0; if_write_ce = 1'b0; if_read = '0; if_read_ce = '0;
    endtask

    initial begin
        logic [DW-1:0] v;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;

        // Two writes, no reads: both consumers see the first token.
        cyc(1, 4'hA, 2'b00);
        chk("empty_n after 1st write", int'(if_empty_n), 3);
        cyc(1, 4'hB, 2'b00);
        chk("dout0 head", int'(if_dout[3:0]), 'hA);
        chk("dout1 head", int'(if_dout[7:4]), 'hA);
        chk("count two", int'(if_count), 2);

        // Consumer 0 drains, consumer 1 idles: occupancy held by the slow one.
        cyc(0, 0, 2'b01);
        cyc(0, 0, 2'b01);
        chk("c0 empty", int'(if_empty_n[0]), 0);
        chk("c1 dout", int'(if_dout[7:4]), 'hA);
        chk("count held", int'(if_count), 2);
        chk("full_n held", int'(if_full_n), 1);
        cyc(0, 0, 2'b10);
        cyc(0, 0, 2'b10);

        // Fill to DEPTH, then one write that must be dropped.
        for (int k = 0; k < D; k++) cyc(1, 4'(k + 1), 2'b00);
        chk("full_n at full", int'(if_full_n), 0);
        chk("afull_n at full", int'(if_almost_full_n), 0);
        cyc(1, 4'hF, 2'b00);
        chk("count after blocked write", int'(if_count), 4);

        // Consumer 0 reads all, consumer 1 reads one: room for one more.
        cyc(0, 0, 2'b11);
        for (int k = 0; k < D - 1; k++) cyc(0, 0, 2'b01);
        chk("count after partial drain", int'(if_count), 3);
        chk("full_n after partial drain", int'(if_full_n), 1);
        cyc(1, 4'h7, 2'b00);
        chk("count after accepted write", int'(if_count), 4);
        for (int k = 0; k < D; k++) cyc(0, 0, 2'b10);
        cyc(0, 0, 2'b01);
        chk("count drained", int'(if_count), 0);

        // Steady state at count=2 with simultaneous write and reads.
        cyc(1, 4'h1, 2'b00);
        cyc(1, 4'h2, 2'b00);
        for (int k = 0; k < 20; k++) cyc(1, 4'(k + 3), 2'b11);
        chk("count steady", int'(if_count), 2);

        // Reset mid-stream at count=3 alongside a write.
        cyc(1, 4'h9, 2'b00);
        chk("count three", int'(if_count), 3);
        reset = 1'b1;
        cyc(1, 4'hC, 2'b11);
        reset = 1'b0;
        chk("count after reset", int'(if_count), 0);
        chk("empty_n after reset", int'(if_empty_n), 0);
        chk("full_n after reset", int'(if_full_n), 1);

        // Randomized traffic with a variety of consumer speeds.
        for (int k = 0; k < 600; k++) begin
            if_write    = ($urandom_range(0, 99) < 60);
            if_write_ce = ($urandom_range(0, 9) != 0);
            v           = 4'($urandom);
            if_din      = v;
            if_read[0]  = ($urandom_range(0, 99) < 70);
            if_read[1]  = ($urandom_range(0, 99) < ((k < 300) ? 30 : 80));
            if_read_ce  = NR'($urandom);
            if_read_ce  = if_read_ce | NR'($urandom);
            @(posedge clk);
            #1;
        end
        if_write = 1'b0; if_write_ce = 1'b0; if_read = '0; if_read_ce = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
